// File: rtl/grf_wb_arbiter.sv
// Write-back arbiter for the single GRF write port: merges the pipeline W-stage
// write with writes from a small in-order FIFO fed by the mul/div unit.
module grf_wb_arbiter #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        p_valid,
  input  logic [31:0] p_pc,
  input  logic [4:0]  p_addr,
  input  logic [31:0] p_data,
  input  logic        m_valid,
  input  logic [31:0] m_pc,
  input  logic [4:0]  m_addr,
  input  logic [31:0] m_data,
  output logic        m_ready,
  input  logic [4:0]  q1_addr,
  input  logic [4:0]  q2_addr,
  output logic        q1_busy,
  output logic        q2_busy,
  output logic        stall_req,
  output logic        reg_write,
  output logic [4:0]  reg_addr,
  output logic [31:0] reg_data,
  output logic [31:0] wpc
);

  localparam int PW = (DEPTH > 2) ? 2 : 1;
  localparam int CW = PW + 1;

  typedef enum logic {NORMAL, FORCE_M} state_t;

  // Handshake: an M write transfers on any posedge where m_valid && m_ready;
  // m_ready depends only on the registered count, never on m_valid.
  state_t          state, state_nxt;
  logic [1:0]      starve, starve_nxt;
  logic [PW-1:0]   head, tail;
  logic [CW-1:0]   count;
  logic [31:0]     fifo_pc   [DEPTH];
  logic [4:0]      fifo_addr [DEPTH];
  logic [31:0]     fifo_data [DEPTH];

  logic p_elig, h_elig, grant_p, grant_h, enq;

  assign p_elig    = p_valid && (p_addr != 5'd0);
  assign h_elig    = (count != '0);
  assign m_ready   = (count < CW'(DEPTH));
  assign enq       = m_valid && m_ready && (m_addr != 5'd0);
  assign stall_req = (state == FORCE_M);

  always_comb begin
    grant_p    = 1'b0;
    grant_h    = 1'b0;
    state_nxt  = state;
    starve_nxt = starve;
    case (state)
      NORMAL: begin
        if (p_elig)      grant_p = 1'b1;
        else if (h_elig) grant_h = 1'b1;
        if (grant_h || !h_elig) starve_nxt = 2'd0;
        else if (grant_p)       starve_nxt = starve + 2'd1;
        if (starve_nxt == 2'd3) state_nxt = FORCE_M;
      end
      FORCE_M: begin
        grant_h    = h_elig;
        starve_nxt = 2'd0;
        state_nxt  = NORMAL;
      end
      default: state_nxt = NORMAL;
    endcase
  end

  // Outputs are gated by reset so a live P request cannot write during reset.
  always_comb begin
    reg_write = 1'b0;
    reg_addr  = 5'd0;
    reg_data  = 32'd0;
    wpc       = 32'd0;
    if (!reset && grant_p) begin
      reg_write = 1'b1;
      reg_addr  = p_addr;
      reg_data  = p_data;
      wpc       = p_pc;
    end else if (!reset && grant_h) begin
      reg_write = 1'b1;
      reg_addr  = fifo_addr[head];
      reg_data  = fifo_data[head];
      wpc       = fifo_pc[head];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= NORMAL;
      starve <= 2'd0;
      head   <= '0;
      tail   <= '0;
      count  <= '0;
    end else begin
      state  <= state_nxt;
      starve <= starve_nxt;
      if (enq)     tail <= (tail == PW'(DEPTH - 1)) ? '0 : tail + 1'b1;
      if (grant_h) head <= (head == PW'(DEPTH - 1)) ? '0 : head + 1'b1;
      if (enq && !grant_h)      count <= count + 1'b1;
      else if (!enq && grant_h) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      fifo_pc[tail]   <= m_pc;
      fifo_addr[tail] <= m_addr;
      fifo_data[tail] <= m_data;
    end
  end

  // An entry is live when its distance from head is below count.
  always_comb begin
    q1_busy = 1'b0;
    q2_busy = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (((i - int'(head) + DEPTH) % DEPTH) < int'(count)) begin
        if ((q1_addr != 5'd0) && (fifo_addr[i] == q1_addr)) q1_busy = 1'b1;
        if ((q2_addr != 5'd0) && (fifo_addr[i] == q2_addr)) q2_busy = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_grf_wb_arbiter.sv
// Directed bench for grf_wb_arbiter (DEPTH=2) with hand-computed expectations.
module tb_grf_wb_arbiter;

  logic        clk, reset;
  logic        p_valid, m_valid, m_ready;
  logic [31:0] p_pc, p_data, m_pc, m_data;
  logic [4:0]  p_addr, m_addr, q1_addr, q2_addr;
  logic        q1_busy, q2_busy, stall_req, reg_write;
  logic [4:0]  reg_addr;
  logic [31:0] reg_data, wpc;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] e;

  grf_wb_arbiter #(.DEPTH(2)) dut (
    .clk(clk), .reset(reset),
    .p_valid(p_valid), .p_pc(p_pc), .p_addr(p_addr), .p_data(p_data),
    .m_valid(m_valid), .m_pc(m_pc), .m_addr(m_addr), .m_data(m_data),
    .m_ready(m_ready),
    .q1_addr(q1_addr), .q2_addr(q2_addr), .q1_busy(q1_busy), .q2_busy(q2_busy),
    .stall_req(stall_req),
    .reg_write(reg_write), .reg_addr(reg_addr), .reg_data(reg_data), .wpc(wpc)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic idle();
    p_valid = 0; p_pc = 0; p_addr = 0; p_data = 0;
    m_valid = 0; m_pc = 0; m_addr = 0; m_data = 0;
    q1_addr = 0; q2_addr = 0;
  endtask

  task automatic drive_p(input logic [4:0] a, input logic [31:0] d, input logic [31:0] pc);
    p_valid = 1; p_addr = a; p_data = d; p_pc = pc;
  endtask

  task automatic drive_m(input logic [4:0] a, input logic [31:0] d, input logic [31:0] pc);
    m_valid = 1; m_addr = a; m_data = d; m_pc = pc;
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  initial begin
    reset = 1'b1;
    idle();
    drive_p(5'd5, 32'h55, 32'h10);
    q1_addr = 5'd5;
    #3;
    check("rst_we", reg_write, 0);
    check("rst_ready", m_ready, 1);
    check("rst_stall", stall_req, 0);
    check("rst_busy", q1_busy, 0);
    @(negedge clk);
    reset = 1'b0;
    idle();
    next();

    // P only
    drive_p(5'd5, 32'h1234, 32'h3000);
    settle();
    check("p_we", reg_write, 1);
    check("p_addr", reg_addr, 5);
    check("p_data", reg_data, 32'h1234);
    check("p_wpc", wpc, 32'h3000);
    p_addr = 5'd0;
    settle();
    check("p0_we", reg_write, 0);
    next();

    // M to $0 is discarded
    idle();
    drive_m(5'd0, 32'hdead, 32'h4);
    settle();
    check("m0_ready", m_ready, 1);
    next();
    idle();
    settle();
    check("m0_we", reg_write, 0);
    next();

    // M only, latency 1
    drive_m(5'd7, 32'hA, 32'h100);
    q1_addr = 5'd7;
    settle();
    check("m_c0_we", reg_write, 0);
    check("m_c0_busy", q1_busy, 0);
    next();
    idle();
    q1_addr = 5'd7;
    settle();
    check("m_c1_busy", q1_busy, 1);
    check("m_c1_we", reg_write, 1);
    check("m_c1_addr", reg_addr, 7);
    check("m_c1_data", reg_data, 32'hA);
    check("m_c1_wpc", wpc, 32'h100);
    next();
    settle();
    check("m_c2_busy", q1_busy, 0);
    check("m_c2_we", reg_write, 0);
    next();

    // starvation -> FORCE_M
    idle();
    drive_m(5'd3, 32'h33, 32'h200);
    next();
    idle();
    drive_p(5'd9, 32'h99, 32'h500);
    drive_m(5'd4, 32'h44, 32'h204);
    q1_addr = 5'd3; q2_addr = 5'd4;
    settle();
    check("sv_c1_addr", reg_addr, 9);
    check("sv_c1_busy1", q1_busy, 1);
    check("sv_c1_busy2", q2_busy, 0);
    next();
    m_valid = 0;
    settle();
    check("sv_c2_addr", reg_addr, 9);
    check("sv_c2_busy2", q2_busy, 1);
    check("sv_c2_stall", stall_req, 0);
    next();
    settle();
    check("sv_c3_addr", reg_addr, 9);
    check("sv_c3_stall", stall_req, 0);
    next();
    settle();
    check("sv_c4_stall", stall_req, 1);
    check("sv_c4_we", reg_write, 1);
    check("sv_c4_addr", reg_addr, 3);
    check("sv_c4_data", reg_data, 32'h33);
    check("sv_c4_wpc", wpc, 32'h200);
    next();
    settle();
    check("sv_c5_stall", stall_req, 0);
    check("sv_c5_addr", reg_addr, 9);
    next();
    idle();
    settle();
    check("sv_c6_addr", reg_addr, 4);
    check("sv_c6_data", reg_data, 32'h44);
    next();
    settle();
    check("sv_c7_we", reg_write, 0);
    next();

    // fill to DEPTH, full with H granted, simultaneous enq/deq at count 1
    drive_p(5'd9, 32'h99, 32'h500);
    drive_m(5'd1, 32'h11, 32'h300);
    next();
    drive_m(5'd2, 32'h22, 32'h304);
    settle();
    check("fl_c1_ready", m_ready, 1);
    next();
    idle();
    drive_m(5'd3, 32'h33, 32'h308);
    settle();
    check("fl_c2_ready", m_ready, 0);
    check("fl_c2_addr", reg_addr, 1);
    check("fl_c2_data", reg_data, 32'h11);
    next();
    settle();
    check("fl_c3_ready", m_ready, 1);
    check("fl_c3_addr", reg_addr, 2);
    check("fl_c3_data", reg_data, 32'h22);
    next();
    idle();
    settle();
    check("fl_c4_we", reg_write, 1);
    check("fl_c4_addr", reg_addr, 3);
    check("fl_c4_data", reg_data, 32'h33);
    check("fl_c4_ready", m_ready, 1);
    next();
    settle();
    check("fl_c5_we", reg_write, 0);
    next();

    // scoreboard: 10 back-to-back M writes, pointer wrap
    for (int i = 0; i <= 10; i++) begin
      idle();
      if (i < 10) drive_m(5'(i + 1), 32'h100 + 32'(i), 32'h2000 + 32'(4 * i));
      settle();
      check("wr_ready", m_ready, 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("wr_we", reg_write, 1);
        check("wr_data", reg_data, e);
      end else begin
        check("wr_idle", reg_write, 0);
      end
      if (i < 10) exp_q.push_back(32'h100 + 32'(i));
      next();
    end
    settle();
    check("wr_end_we", reg_write, 0);

    // reset mid-cycle with two entries queued
    drive_p(5'd9, 32'h99, 32'h500);
    drive_m(5'd6, 32'h66, 32'h600);
    next();
    drive_m(5'd7, 32'h77, 32'h604);
    next();
    idle();
    q1_addr = 5'd7;
    settle();
    check("rm_pre_we", reg_write, 1);
    check("rm_pre_addr", reg_addr, 6);
    check("rm_pre_ready", m_ready, 0);
    check("rm_pre_busy", q1_busy, 1);
    reset = 1'b1;
    #1;
    check("rm_we", reg_write, 0);
    check("rm_ready", m_ready, 1);
    check("rm_busy", q1_busy, 0);
    check("rm_stall", stall_req, 0);
    @(posedge clk);
    #2;
    @(negedge clk);
    reset = 1'b0;
    drive_m(5'd8, 32'h88, 32'h700);
    next();
    idle();
    q1_addr = 5'd7;
    settle();
    check("rm_first_we", reg_write, 1);
    check("rm_first_addr", reg_addr, 8);
    check("rm_first_data", reg_data, 32'h88);
    check("rm_first_busy7", q1_busy, 0);
    next();
    settle();
    check("rm_after_we", reg_write, 0);
    next();
    settle();
    check("rm_after2_we", reg_write, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
